cu_sequencer: RTL and testbench



---
 rtl/cu_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_cu_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_sequencer.sv
// CPU control unit: fetches 16-bit instructions over the MMU get/set/rdy handshake,
// sequences the external combinational ALU and a small register file, and runs LOAD/STORE.
module cu_sequencer #(
  parameter logic [15:0] RESET_IPR = 16'h0000,
  parameter int unsigned NREGS     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MMU_rdy,
  input  logic [15:0] MMU_rx_data,
  output logic [15:0] MMU_tx_data,
  output logic [15:0] MMU_addr,
  output logic        MMU_get,
  output logic        MMU_set,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_operand1,
  output logic [15:0] alu_operand2,
  input  logic [15:0] alu_result,
  output logic        halted,
  output logic        illegal_op,
  output logic [15:0] dbg_ipr
);

  localparam logic [2:0] StFetch     = 3'd0;
  localparam logic [2:0] StFetchWait = 3'd1;
  localparam logic [2:0] StDecode    = 3'd2;
  localparam logic [2:0] StExec      = 3'd3;
  localparam logic [2:0] StMemReq    = 3'd4;
  localparam logic [2:0] StMemWait   = 3'd5;
  localparam logic [2:0] StHalt      = 3'd6;

  localparam logic [3:0] OpDiv   = 4'h4;
  localparam logic [3:0] OpLdi   = 4'h7;
  localparam logic [3:0] OpLoad  = 4'h8;
  localparam logic [3:0] OpStore = 4'h9;
  localparam logic [3:0] OpHalt  = 4'hF;

  logic [2:0]  state_q, state_d;
  logic [15:0] ipr_q, ipr_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] regs_q [NREGS];
  logic [15:0] regs_d [NREGS];
  logic [15:0] addr_q, addr_d;
  logic [15:0] tx_q, tx_d;
  logic        get_q, get_d;
  logic        set_q, set_d;
  logic [3:0]  opc_q, opc_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;

  logic [3:0] op;
  logic [1:0] rd, rs1, rs2;

  assign op  = ir_q[15:12];
  assign rd  = ir_q[11:10];
  assign rs1 = ir_q[9:8];
  assign rs2 = ir_q[7:6];

  always_comb begin
    state_d   = state_q;
    ipr_d     = ipr_q;
    ir_d      = ir_q;
    regs_d    = regs_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    get_d     = 1'b0;
    set_d     = 1'b0;
    opc_d     = opc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;

    case (state_q)
      StFetch: begin
        addr_d  = ipr_q;
        get_d   = 1'b1;
        state_d = StFetchWait;
      end
      StFetchWait: begin
        if (MMU_rdy) begin
          ir_d    = MMU_rx_data;
          ipr_d   = ipr_q + 16'd1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        opc_d = op;
        opa_d = regs_q[rs1];
        opb_d = regs_q[rs2];
        if (op <= OpDiv) begin
          state_d = StExec;
        end else begin
          case (op)
            OpLdi: begin
              regs_d[rd] = {8'h00, ir_q[7:0]};
              state_d    = StFetch;
            end
            OpLoad, OpStore: state_d = StMemReq;
            OpHalt: begin
              halted_d = 1'b1;
              state_d  = StHalt;
            end
            default: begin
              illegal_d = 1'b1;
              state_d   = StFetch;
            end
          endcase
        end
      end
      StExec: begin
        regs_d[rd] = alu_result;
        state_d    = StFetch;
      end
      StMemReq: begin
        addr_d = regs_q[rs1];
        if (op == OpStore) begin
          set_d = 1'b1;
          tx_d  = regs_q[rs2];
        end else begin
          get_d = 1'b1;
        end
        state_d = StMemWait;
      end
      StMemWait: begin
        if (MMU_rdy) begin
          if (op == OpLoad) regs_d[rd] = MMU_rx_data;
          state_d = StFetch;
        end
      end
      StHalt: halted_d = 1'b1;
      default: state_d = StFetch;
    endcase
  end

  // Reset abandons any outstanding transfer; a late rdy lands in StFetch and is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      ipr_q     <= RESET_IPR;
      ir_q      <= '0;
      addr_q    <= '0;
      tx_q      <= '0;
      get_q     <= 1'b0;
      set_q     <= 1'b0;
      opc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ipr_q     <= ipr_d;
      ir_q      <= ir_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      get_q     <= get_d;
      set_q     <= set_d;
      opc_q     <= opc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      regs_q    <= regs_d;
    end
  end

  assign MMU_addr     = addr_q;
  assign MMU_tx_data  = tx_q;
  assign MMU_get      = get_q;
  assign MMU_set      = set_q;
  assign alu_opcode   = opc_q;
  assign alu_operand1 = opa_q;
  assign alu_operand2 = opb_q;
  assign halted       = halted_q;
  assign illegal_op   = illegal_q;
  assign dbg_ipr      = ipr_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Bench for cu_sequencer: bench-side ALU and MMU memory, an instruction-level model that
// predicts every MMU transfer and fetch spacing, and literal checks on directed programs.
module tb_cu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire         MMU_rdy;
  wire  [15:0] MMU_rx_data;
  logic [15:0] MMU_tx_data, MMU_addr;
  logic        MMU_get, MMU_set;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_operand1, alu_operand2;
  wire  [15:0] alu_result;
  logic        halted, illegal_op;
  logic [15:0] dbg_ipr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        is_fetch;
    logic        is_set;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  txn_t        exp_q [$];
  int          gap_q [$];
  int          obs_gap [$];
  logic [15:0] prog [$];
  logic [15:0] mem [1024];
  logic [15:0] exp_ipr;
  logic        exp_ill;

  int          wait_cycles = 0;
  bit          spurious = 1'b0;
  logic        force_rdy = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [15:0] resp_data = 16'h0000;
  bit          pending = 1'b0;
  int          cnt = 0;
  logic [15:0] req_addr, req_data;
  logic        req_set;

  int          cyc = 0;
  int          last_fetch = 0;
  bit          have_last = 1'b0;
  bit          pulse_chk = 1'b0;
  int          set_cnt = 0;
  logic [15:0] last_set_addr = 16'h0000;
  logic [15:0] last_set_data = 16'h0000;
  txn_t        e;
  int          n;
  bit          seen;

  assign MMU_rdy     = resp_rdy | force_rdy;
  assign MMU_rx_data = force_rdy ? 16'hBEEF : resp_data;

  always #5 clk = ~clk;

  // Reference ALU: Lshf shifts operand 1 up a byte and merges operand 2's low byte.
  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [31:0] p;
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return {a[7:0], b[7:0]};
      4'h3: begin
        p = 32'(a) * 32'(b);
        return p[15:0];
      end
      4'h4: return (b == 16'h0) ? 16'h0 : a / b;
      default: return 16'h0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_operand1, alu_operand2);

  cu_sequencer #(
    .RESET_IPR(16'h0000),
    .NREGS    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .MMU_rdy     (MMU_rdy),
    .MMU_rx_data (MMU_rx_data),
    .MMU_tx_data (MMU_tx_data),
    .MMU_addr    (MMU_addr),
    .MMU_get     (MMU_get),
    .MMU_set     (MMU_set),
    .alu_opcode  (alu_opcode),
    .alu_operand1(alu_operand1),
    .alu_operand2(alu_operand2),
    .alu_result  (alu_result),
    .halted      (halted),
    .illegal_op  (illegal_op),
    .dbg_ipr     (dbg_ipr)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Instruction-level interpreter over a copy of memory, w = MMU wait cycles per transfer.
  task automatic build_model(input int w);
    logic [15:0] r [4];
    logic [15:0] m [1024];
    logic [15:0] ipr, ir, a;
    logic [3:0]  op;
    bit          done;
    for (int i = 0; i < 4; i++) r[i] = 16'h0;
    m = mem;
    ipr = 16'h0000;
    exp_ill = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      ir = m[ipr[9:0]];
      exp_q.push_back('{1'b1, 1'b0, ipr, 16'h0000});
      ipr = ipr + 16'd1;
      op = ir[15:12];
      a = r[ir[9:8]];
      if (op <= 4'h4) begin
        r[ir[11:10]] = alu_f(op, a, r[ir[7:6]]);
        gap_q.push_back(4 + w);
      end else if (op == 4'h7) begin
        r[ir[11:10]] = {8'h00, ir[7:0]};
        gap_q.push_back(3 + w);
      end else if (op == 4'h8) begin
        exp_q.push_back('{1'b0, 1'b0, a, 16'h0000});
        r[ir[11:10]] = m[a[9:0]];
        gap_q.push_back(5 + 2 * w);
      end else if (op == 4'h9) begin
        exp_q.push_back('{1'b0, 1'b1, a, r[ir[7:6]]});
        m[a[9:0]] = r[ir[7:6]];
        gap_q.push_back(5 + 2 * w);
      end else if (op == 4'hF) begin
        done = 1'b1;
      end else begin
        exp_ill = 1'b1;
        gap_q.push_back(3 + w);
      end
    end
    exp_ipr = ipr;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
  endtask

  task automatic start_prog(input int w, input bit spur);
    rst = 1'b1;
    wait_cycles = w;
    spurious = spur;
    force_rdy = 1'b0;
    load_mem();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_get", 16'(MMU_get), 16'h0);
    chk("rst_set", 16'(MMU_set), 16'h0);
    chk("rst_addr", MMU_addr, 16'h0);
    chk("rst_tx", MMU_tx_data, 16'h0);
    chk("rst_opcode", 16'(alu_opcode), 16'h0);
    chk("rst_op1", alu_operand1, 16'h0);
    chk("rst_op2", alu_operand2, 16'h0);
    chk("rst_halted", 16'(halted), 16'h0);
    chk("rst_illegal", 16'(illegal_op), 16'h0);
    chk("rst_ipr", dbg_ipr, 16'h0);
    build_model(w);
    rst = 1'b0;
  endtask

  task automatic finish_prog();
    int k = 0;
    while (!halted && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("halt_reached", 16'(halted), 16'h1);
    repeat (5) @(posedge clk);
    #1;
    chk("exp_queue_drained", 16'(exp_q.size()), 16'h0);
    chk("final_ipr", dbg_ipr, exp_ipr);
    chk("illegal_flag", 16'(illegal_op), 16'(exp_ill));
    chk("halt_held", 16'(halted), 16'h1);
  endtask

  // MMU responder: serves each request after wait_cycles, optionally pulses rdy when idle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 1'b0;
        resp_rdy = 1'b0;
        continue;
      end
      if (MMU_get || MMU_set) begin
        pending = 1'b1;
        cnt = wait_cycles;
        req_addr = MMU_addr;
        req_set = MMU_set;
        req_data = MMU_tx_data;
      end
      if (pending) begin
        if (cnt == 0) begin
          chk("addr_stable", MMU_addr, req_addr);
          if (req_set) begin
            chk("tx_stable", MMU_tx_data, req_data);
            mem[req_addr[9:0]] = req_data;
          end else begin
            resp_data = mem[req_addr[9:0]];
          end
          resp_rdy = 1'b1;
          pending = 1'b0;
        end else begin
          cnt--;
          resp_rdy = 1'b0;
        end
      end else begin
        resp_rdy = spurious;
        resp_data = 16'hDEAD;
      end
    end
  end

  // Compare process: every new MMU request against the model, plus pulse width and spacing.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        gap_q.delete();
        obs_gap.delete();
        have_last = 1'b0;
        pulse_chk = 1'b0;
        set_cnt = 0;
        continue;
      end
      if (pulse_chk) begin
        chk("req_pulse", {14'h0, MMU_get, MMU_set}, 16'h0);
        pulse_chk = 1'b0;
      end else if (MMU_get || MMU_set) begin
        pulse_chk = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got request at addr %h, expected none", MMU_addr);
        end else begin
          e = exp_q.pop_front();
          chk("req_kind", 16'(MMU_set), 16'(e.is_set));
          chk("req_addr", MMU_addr, e.addr);
          if (e.is_set) begin
            chk("set_data", MMU_tx_data, e.data);
            set_cnt++;
            last_set_addr = MMU_addr;
            last_set_data = MMU_tx_data;
          end
          if (e.is_fetch) begin
            if (have_last && gap_q.size() > 0) begin
              obs_gap.push_back(cyc - last_fetch);
              chk("fetch_gap", 16'(cyc - last_fetch), 16'(gap_q.pop_front()));
            end
            have_last = 1'b1;
            last_fetch = cyc;
          end
        end
      end
    end
  end

  initial begin
    // LDI/LDI/ADD/STORE/HALT, zero-wait
    prog = '{16'h7005, 16'h7403, 16'h0840, 16'h9180, 16'hF000};
    start_prog(0, 1'b0);
    finish_prog();
    chk("t1_set_cnt", 16'(set_cnt), 16'd1);
    chk("t1_set_addr", last_set_addr, 16'h0003);
    chk("t1_set_data", last_set_data, 16'h0008);
    chk("t1_ipr", dbg_ipr, 16'h0005);

    // byte-merge shift, then ALU latency
    prog = '{16'h7012, 16'h7434, 16'h2840, 16'h9080, 16'hF000};
    start_prog(0, 1'b0);
    finish_prog();
    chk("t2_set_addr", last_set_addr, 16'h0012);
    chk("t2_set_data", last_set_data, 16'h1234);
    chk("t2_gap_count", 16'(obs_gap.size()), 16'd4);
    chk("t2_alu_gap", 16'(obs_gap[2]), 16'd4);

    // divide by zero, then 0x100 * 0x100 truncating to zero
    prog = '{16'h7C55, 16'h7007, 16'h4C40, 16'h7001, 16'h2040, 16'h0480, 16'h3840,
             16'h90C0, 16'h9180, 16'hF000};
    start_prog(0, 1'b0);
    finish_prog();
    chk("t3_set_cnt", 16'(set_cnt), 16'd2);
    chk("t3_set_addr", last_set_addr, 16'h0100);
    chk("t3_set_data", last_set_data, 16'h0000);

    // three MMU wait cycles per transfer with spurious rdy while idle
    prog = '{16'h7012, 16'h7434, 16'h2840, 16'h9080, 16'hF000};
    start_prog(3, 1'b1);
    finish_prog();
    chk("t4_set_data", last_set_data, 16'h1234);
    chk("t4_alu_gap", 16'(obs_gap[2]), 16'd7);
    chk("t4_store_gap", 16'(obs_gap[3]), 16'd11);

    // undefined opcode behaves as a sticky-flagged NOP
    prog = '{16'h7011, 16'h7422, 16'h5000, 16'h9040, 16'hF000};
    start_prog(0, 1'b0);
    finish_prog();
    chk("t5_illegal", 16'(illegal_op), 16'h1);
    chk("t5_set_addr", last_set_addr, 16'h0011);
    chk("t5_set_data", last_set_data, 16'h0022);
    chk("t5_nop_gap", 16'(obs_gap[2]), 16'd3);
    chk("t5_ipr", dbg_ipr, 16'h0005);

    // reset while a LOAD waits, then a late rdy
    prog = '{16'h7011, 16'h7422, 16'h7833, 16'h7C44, 16'h8C00, 16'hF000};
    start_prog(3, 1'b0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 500) begin
      @(negedge clk);
      if (MMU_get && MMU_addr == 16'h0011) seen = 1'b1;
      n++;
    end
    chk("t6_load_seen", 16'(seen), 16'h1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_get", 16'(MMU_get), 16'h0);
    chk("t6_rst_set", 16'(MMU_set), 16'h0);
    chk("t6_rst_ipr", dbg_ipr, 16'h0000);
    @(negedge clk);
    #1;
    prog = '{16'h9000, 16'h9040, 16'h9080, 16'h90C0, 16'hF000};
    load_mem();
    build_model(3);
    rst = 1'b0;
    force_rdy = 1'b1;
    @(negedge clk);
    #1 force_rdy = 1'b0;
    finish_prog();
    chk("t6_set_cnt", 16'(set_cnt), 16'd4);
    chk("t6_set_addr", last_set_addr, 16'h0000);
    chk("t6_set_data", last_set_data, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
